// File: rtl/perf_counter_bank.sv
// Per-channel event counters plus a free-running cycle counter, with an atomic shadow
// snapshot and a registered read port. Define PERF_SAT_EN for saturating counters (default: wrap).
module perf_counter_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ev,
    input  logic              halt,
    input  logic              clear,
    input  logic              snap,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic              rd_en,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH:0]   ovf,
    output logic              frozen
);

    localparam int unsigned      NCNT    = NUM_CH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PERF_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic {
        S_RUN    = 1'b0,
        S_FROZEN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             frozen_q, frozen_d;
    logic [CNT_W-1:0] cnt_q    [NCNT];
    logic [CNT_W-1:0] cnt_d    [NCNT];
    logic [CNT_W-1:0] shadow_q [NCNT];
    logic [CNT_W-1:0] shadow_d [NCNT];
    logic [NUM_CH:0]  ovf_q, ovf_d;
    logic [NUM_CH:0]  inc_c;
    logic             count_en_c;
    logic [CNT_W-1:0] rd_mux_c;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    // Next-state logic: clear always returns to RUN, halt is only honoured while running
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:    if (halt) state_d = S_FROZEN;
                S_FROZEN: state_d = S_FROZEN;
                default:  state_d = S_RUN;
            endcase
        end
        frozen_d = (state_d == S_FROZEN);
    end

    // The halt cycle still counts because the gate uses the current state, not the next one
    assign count_en_c = (state_q == S_RUN) && en && !clear;
    assign inc_c      = {count_en_c, ev & {NUM_CH{count_en_c}}};

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < int'(NCNT); i++) begin
            cnt_d[i]    = cnt_q[i];
            shadow_d[i] = shadow_q[i];
            if (clear) begin
                cnt_d[i]    = '0;
                shadow_d[i] = '0;
            end else begin
                if (snap) shadow_d[i] = cnt_q[i];
                if (inc_c[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = SAT_EN ? CNT_MAX : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
        if (clear) ovf_d = '0;
    end

    // Read mux over the pre-snapshot shadows; indices past the cycle counter read as zero
    always_comb begin
        rd_mux_c = '0;
        for (int i = 0; i < int'(NCNT); i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux_c = shadow_q[i];
        end
        rd_data_d = rd_en ? rd_mux_c : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            frozen_q   <= 1'b0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < int'(NCNT); i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            frozen_q   <= frozen_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            for (int i = 0; i < int'(NCNT); i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;
    assign frozen   = frozen_q;

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable bank of per-channel event counters plus a free-running cycle counter. It sits beside the processor core in `proc_hier` and moves the instruction and cache hit/request accounting out of the bench and into hardware. Counting freezes automatically on halt. An atomic snapshot into shadow registers feeds a registered read port, so software or the bench can read a consistent set of values.

## Interface
Parameters:
- `NUM_CH`, default 4: number of event channels, 1..15.
- `CNT_W`, default 32: width of every counter, 8..32.
- `SEL_W`, default 4: read-select width; must satisfy 2^SEL_W > NUM_CH.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: global count enable.
- `ev`  in  NUM_CH: per-channel event strobes, sampled every cycle.
- `halt`  in  1: processor halt; freezes the bank.
- `clear`  in  1: synchronous clear of counters, flags and state.
- `snap`  in  1: copy live counters into the shadow registers.
- `rd_sel`  in  SEL_W: read index. 0..NUM_CH-1 selects a channel; NUM_CH selects the cycle counter.
- `rd_en`  in  1: read request.
- `rd_data`  out  CNT_W: shadow value for the selected index.
- `rd_valid`  out  1: `rd_data` is valid this cycle.
- `ovf`  out  NUM_CH+1: sticky overflow flags. Bit NUM_CH is the cycle counter.
- `frozen`  out  1: the bank is in the FROZEN state.

## Operation
- State machine with two states, RUN and FROZEN. Reset state is RUN.
  - RUN → FROZEN when `halt`=1 and `clear`=0.
  - FROZEN → RUN only on `clear`=1.
- In RUN with `en`=1:
  - channel i increments by 1 when `ev[i]`=1;
  - the cycle counter increments by 1 every cycle.
- In RUN with `en`=0, nothing counts.
- The halt cycle itself is counted: events and the cycle tick present when `halt` is sampled are still added. This matches "halted instruction counts".
- In FROZEN, all `ev`, `en` and `halt` inputs are ignored. `snap` and reads still work.
- `clear` has priority over every other input in the same cycle:
  - all live counters, shadows and `ovf` go to 0;
  - state goes to RUN;
  - any event in that cycle is dropped.
- `snap`: each shadow register is loaded with the live counter's current registered value, i.e. before this cycle's increment. All channels and the cycle counter are captured in the same edge.
- Read port:
  - `rd_en`=1 registers `rd_data` = shadow[`rd_sel`];
  - an index greater than NUM_CH returns 0, with `rd_valid` still asserted.
- `snap` and `rd_en` in the same cycle: the read returns the old shadow value.
- Overflow: an increment from all-ones sets the sticky `ovf` bit for that counter. The bit stays set until `clear` or reset.
- Arithmetic is unsigned, modulo 2^CNT_W (wrap) unless `PERF_SAT_EN` is defined.

## Timing
- Reset (`rst`=0, asynchronous) clears:
  - all counters and shadows to 0;
  - `rd_data`=0, `rd_valid`=0, `ovf`=0, `frozen`=0;
  - state to RUN.
- Counter update latency is 1 cycle: an event at edge N is visible in the live counter after edge N.
- `frozen` is registered and asserts the cycle after `halt` is sampled.
- Read latency is 1 cycle: `rd_valid`=1 and `rd_data` valid on the cycle after `rd_en`. `rd_valid` is a single-cycle pulse per request. Back-to-back reads are allowed, one per cycle.
- Reset asserted mid-operation aborts everything immediately. No partial snapshot survives.

## Configuration
- `PERF_SAT_EN` defined: counters saturate at 2^CNT_W−1 and hold there.
  - The `ovf` bit is set on the first increment attempted at all-ones.
  - The counter never wraps to 0.
- `PERF_SAT_EN` undefined: counters wrap from all-ones to 0, and `ovf` is set on that wrap.

## Test plan
- Reset release: hold `rst`=0 for 3 cycles, release, and read all indices → every `rd_data`=0, `ovf`=0, `frozen`=0.
- Count and snapshot:
  - `en`=1, pulse `ev[0]` on 5 cycles and `ev[2]` on 3 cycles over 10 cycles, then `snap`;
  - read indices 0, 2, 4 → 5, 3, 10;
  - `rd_valid` high exactly 1 cycle after each `rd_en`.
- Halt freeze:
  - `ev[1]`=1 continuously, assert `halt` at cycle 6, keep `ev[1]` high 10 more cycles, then `snap` and read 1 → 6;
  - `frozen`=1 from cycle 7.
- Clear priority: `clear`, `halt` and `ev[0]` together → channel 0 = 0, state RUN, `frozen`=0 next cycle.
- Overflow with CNT_W=8:
  - 256 events on channel 3 → wraps to 0, `ovf[3]`=1;
  - with `PERF_SAT_EN` defined → holds 255, `ovf[3]`=1.
- Out-of-range read: `rd_sel`=NUM_CH+1 → `rd_data`=0, `rd_valid`=1.
